// File: rtl/std_pkg.sv
// Shared std library types: clock description used to pick the active edge
// of clocked library cells.
package std_pkg;

  typedef enum logic {
    STD_CLOCK_EDGE_RISING  = 1'b0,
    STD_CLOCK_EDGE_FALLING = 1'b1
  } std_clock_edge_t;

  // All-zero value describes a rising-edge clock.
  typedef struct packed {
    std_clock_edge_t clock_edge;
  } std_clock_info_t;

endpackage

// File: rtl/std_enable_register.sv
// Clock-enabled register of arbitrary packed type with optional fixed-latency
// stage chain and a compile-time selectable active clock edge.
module std_enable_register
  import std_pkg::*;
#(
  parameter std_clock_info_t CLOCK_INFO   = 'b0,
  parameter type             T            = logic,
  parameter T                RESET_VECTOR = 'b0,
  parameter int              STAGES       = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  T     next,
  output T     value
);

  // Keeps declarations legal while the STAGES check below reports the error.
  localparam int DEPTH = (STAGES < 1) ? 1 : STAGES;

  if (STAGES < 1) begin : g_bad_stages
    $error("std_enable_register: STAGES must be >= 1");
  end

  T [DEPTH-1:0] stage_q = {DEPTH{RESET_VECTOR}};
  T [DEPTH-1:0] stage_d;

  always_comb begin
    stage_d = stage_q;
    if (enable) begin
      stage_d[0] = next;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  if (CLOCK_INFO.clock_edge == STD_CLOCK_EDGE_FALLING) begin : g_falling
    always_ff @(negedge clk) begin
      if (rst) begin
        stage_q <= {DEPTH{RESET_VECTOR}};
      end else begin
        stage_q <= stage_d;
      end
    end

`ifndef SYNTHESIS
    always @(negedge clk) begin
      if (!rst && $isunknown(enable)) begin
        $warning("std_enable_register: enable is X/Z while not in reset");
      end
    end
`endif
  end else begin : g_rising
    always_ff @(posedge clk) begin
      if (rst) begin
        stage_q <= {DEPTH{RESET_VECTOR}};
      end else begin
        stage_q <= stage_d;
      end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
      if (!rst && $isunknown(enable)) begin
        $warning("std_enable_register: enable is X/Z while not in reset");
      end
    end
`endif
  end

  assign value = stage_q[DEPTH-1];

endmodule

// File: tb/tb_std_enable_register.sv
// Bench for std_enable_register: single-stage rising, three-stage rising and
// single-stage falling-edge instances checked against fixed expectations.
module tb_std_enable_register;
  import std_pkg::*;

  localparam logic [31:0] RV32 = 32'hDEADBEEF;
  localparam logic [7:0]  RV8  = 8'h3C;
  localparam std_clock_info_t CI_RISE = '{clock_edge: STD_CLOCK_EDGE_RISING};
  localparam std_clock_info_t CI_FALL = '{clock_edge: STD_CLOCK_EDGE_FALLING};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst = 1'b0, a_en = 1'b0;
  logic [31:0] a_next = '0, a_value;
  logic        b_rst = 1'b0, b_en = 1'b0;
  logic [31:0] b_next = '0, b_value;
  logic        c_rst = 1'b0, c_en = 1'b0;
  logic [7:0]  c_next = '0, c_value;

  std_enable_register #(
    .CLOCK_INFO(CI_RISE), .T(logic [31:0]), .RESET_VECTOR(RV32), .STAGES(1)
  ) u_a (
    .clk(clk), .rst(a_rst), .enable(a_en), .next(a_next), .value(a_value)
  );

  std_enable_register #(
    .CLOCK_INFO(CI_RISE), .T(logic [31:0]), .RESET_VECTOR(RV32), .STAGES(3)
  ) u_b (
    .clk(clk), .rst(b_rst), .enable(b_en), .next(b_next), .value(b_value)
  );

  std_enable_register #(
    .CLOCK_INFO(CI_FALL), .T(logic [7:0]), .RESET_VECTOR(RV8), .STAGES(1)
  ) u_c (
    .clk(clk), .rst(c_rst), .enable(c_en), .next(c_next), .value(c_value)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    logic [31:0] nx;
    logic [31:0] exp;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive away from the rising edge, sample just after it.
  task automatic apply(input int which, input vec_t v);
    logic [31:0] exp;
    @(negedge clk);
    if (which == 0) begin
      a_rst = v.rst; a_en = v.en; a_next = v.nx;
    end else begin
      b_rst = v.rst; b_en = v.en; b_next = v.nx;
    end
    sb_q.push_back(v.exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({v.name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      check(v.name, (which == 0) ? a_value : b_value, exp);
    end
  endtask

  vec_t vec_a[$];
  vec_t vec_b[$];

  initial begin
    vec_a = '{
      '{"a_reset",      1'b1, 1'b0, 32'h0000_0000, RV32},
      '{"a_load",       1'b0, 1'b1, 32'h1234_5678, 32'h1234_5678},
      '{"a_hold1",      1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678},
      '{"a_hold2",      1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678},
      '{"a_hold3",      1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678},
      '{"a_hold4",      1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678},
      '{"a_hold5",      1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678},
      '{"a_rst_prio",   1'b1, 1'b1, 32'h0000_0001, RV32},
      '{"a_post_rst",   1'b0, 1'b0, 32'h0000_0001, RV32},
      '{"a_load2",      1'b0, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D},
      '{"a_load3",      1'b0, 1'b1, 32'h8000_0001, 32'h8000_0001}
    };
    vec_b = '{
      '{"b_reset",      1'b1, 1'b0, 32'd0,  RV32},
      '{"b_lat1",       1'b0, 1'b1, 32'd1,  RV32},
      '{"b_lat2",       1'b0, 1'b1, 32'd2,  RV32},
      '{"b_out1",       1'b0, 1'b1, 32'd3,  32'd1},
      '{"b_out2",       1'b0, 1'b1, 32'd4,  32'd2},
      '{"b_freeze1",    1'b0, 1'b0, 32'd99, 32'd2},
      '{"b_freeze2",    1'b0, 1'b0, 32'd98, 32'd2},
      '{"b_out3",       1'b0, 1'b1, 32'd5,  32'd3},
      '{"b_out4",       1'b0, 1'b1, 32'd6,  32'd4},
      '{"b_out5",       1'b0, 1'b1, 32'd7,  32'd5},
      '{"b_mid_rst",    1'b1, 1'b0, 32'd0,  RV32},
      '{"b_flush1",     1'b0, 1'b1, 32'd8,  RV32},
      '{"b_flush2",     1'b0, 1'b1, 32'd9,  RV32},
      '{"b_first_post", 1'b0, 1'b1, 32'd10, 32'd8}
    };

    #1;
    check("a_powerup", a_value, RV32);
    check("b_powerup", b_value, RV32);
    check("c_powerup", {24'd0, c_value}, {24'd0, RV8});

    foreach (vec_a[i]) apply(0, vec_a[i]);
    foreach (vec_b[i]) apply(1, vec_b[i]);

    // Falling-edge instance: drive just after the rising edge.
    @(posedge clk); #1;
    c_rst = 1'b1; c_en = 1'b0; c_next = 8'h00;
    @(negedge clk); #1;
    check("c_reset", {24'd0, c_value}, {24'd0, RV8});
    c_rst = 1'b0; c_en = 1'b1; c_next = 8'hA5;
    @(posedge clk); #1;
    check("c_no_load_posedge", {24'd0, c_value}, {24'd0, RV8});
    @(negedge clk); #1;
    check("c_load_negedge", {24'd0, c_value}, 32'h0000_00A5);
    c_en = 1'b0; c_next = 8'h5A;
    @(negedge clk); #1;
    check("c_hold", {24'd0, c_value}, 32'h0000_00A5);
    c_rst = 1'b1; c_en = 1'b1; c_next = 8'hFF;
    @(negedge clk); #1;
    check("c_rst_prio", {24'd0, c_value}, {24'd0, RV8});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
